// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the unified-memory port arbiter.
// Optional alignment checking is enabled by defining MEM_PORT_ARBITER_ALIGN_CHK_EN.
package mem_port_arbiter_pkg;

   localparam int unsigned ADDR_W = 32;
   localparam int unsigned DATA_W = 32;
   localparam int unsigned CNT_W  = 4;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic GNT_IF = 1'b0;
   localparam logic GNT_DM = 1'b1;

   // Request payload of whichever requester wins the grant
   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } req_t;

   function automatic logic is_aligned(input logic [ADDR_W-1:0] addr);
      return addr[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Requester and Memory-side signal bundle of mem_port_arbiter.
// align_err exists only when MEM_PORT_ARBITER_ALIGN_CHK_EN is defined.
interface mem_port_arbiter_if;
   import mem_port_arbiter_pkg::*;

   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic              if_ack;
   logic [DATA_W-1:0] if_rdata;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [DATA_W-1:0] dm_wdata;
   logic              dm_ack;
   logic [DATA_W-1:0] dm_rdata;
   logic              mem_rd;
   logic              mem_wr;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
   logic              align_err;

   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy,
             align_err
   );
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy,
             align_err
   );
`else
   modport slave (
      input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      output if_ack, if_rdata, dm_ack, dm_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
   );
   modport master (
      output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata,
      input  if_ack, if_rdata, dm_ack, dm_rdata, mem_rd, mem_wr, mem_addr, mem_wdata, busy
   );
`endif

endinterface

// File: rtl/mem_arb_pick.sv
// Combinational two-way round-robin pick between fetch and data requests.
module mem_arb_pick
   import mem_port_arbiter_pkg::*;
(
   input  logic if_req,
   input  logic dm_req,
   input  logic last_gnt,
   output logic gnt_valid_c,
   output logic gnt_id_c
);

   // On contention the requester not served last wins
   always_comb begin
      gnt_valid_c = if_req | dm_req;
      if (if_req && dm_req) gnt_id_c = ~last_gnt;
      else if (dm_req)      gnt_id_c = GNT_DM;
      else                  gnt_id_c = GNT_IF;
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single unified Memory between instruction fetch and data access.
// Define MEM_PORT_ARBITER_ALIGN_CHK_EN to reject misaligned grants with align_err.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int unsigned ACCESS_CYCLES = 2
)
(
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              gnt_q, gnt_d;
   logic              last_gnt_q, last_gnt_d;
   logic              mem_rd_q, mem_rd_d;
   logic              mem_wr_q, mem_wr_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_ack_q, if_ack_d;
   logic              dm_ack_q, dm_ack_d;
   logic              busy_q, busy_d;
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
   logic              align_err_q, align_err_d;
`endif

   logic pick_valid_c;
   logic pick_id_c;
   req_t sel;
   logic misaligned;

   mem_arb_pick u_pick (
      .if_req      (bus.if_req),
      .dm_req      (bus.dm_req),
      .last_gnt    (last_gnt_q),
      .gnt_valid_c (pick_valid_c),
      .gnt_id_c    (pick_id_c)
   );

   // Next-state and next-output logic
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      gnt_d       = gnt_q;
      last_gnt_d  = last_gnt_q;
      mem_rd_d    = mem_rd_q;
      mem_wr_d    = mem_wr_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_ack_d    = 1'b0;
      dm_ack_d    = 1'b0;
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
      align_err_d = 1'b0;
`endif

      sel.we    = 1'b0;
      sel.addr  = bus.if_addr;
      sel.wdata = '0;
      if (pick_id_c == GNT_DM) begin
         sel.we    = bus.dm_we;
         sel.addr  = bus.dm_addr;
         sel.wdata = bus.dm_wdata;
      end

`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
      misaligned = !is_aligned(sel.addr);
`else
      misaligned = 1'b0;
`endif

      case (state_q)
         ST_IDLE: begin
            if (pick_valid_c) begin
               gnt_d      = pick_id_c;
               mem_addr_d = sel.addr;
               if (sel.we) mem_wdata_d = sel.wdata;
               if (misaligned) begin
                  state_d = ST_RESP;
               end else begin
                  mem_rd_d = !sel.we;
                  mem_wr_d = sel.we;
                  cnt_d    = CNT_W'(ACCESS_CYCLES - 1);
                  state_d  = ST_ACCESS;
               end
            end
         end
         ST_ACCESS: begin
            if (cnt_q == '0) begin
               if (mem_rd_q) begin
                  if (gnt_q == GNT_DM) dm_rdata_d = bus.mem_rdata;
                  else                 if_rdata_d = bus.mem_rdata;
               end
               mem_rd_d = 1'b0;
               mem_wr_d = 1'b0;
               if (gnt_q == GNT_DM) dm_ack_d = 1'b1;
               else                 if_ack_d = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         ST_RESP: begin
            // A rejected grant arrives here without its ack yet; raise it on this pass
            if (if_ack_q || dm_ack_q) begin
               last_gnt_d = gnt_q;
               state_d    = ST_IDLE;
            end else begin
               if (gnt_q == GNT_DM) dm_ack_d = 1'b1;
               else                 if_ack_d = 1'b1;
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
               align_err_d = 1'b1;
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         cnt_q       <= '0;
         gnt_q       <= GNT_IF;
         last_gnt_q  <= GNT_IF;
         mem_rd_q    <= 1'b0;
         mem_wr_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_ack_q    <= 1'b0;
         dm_ack_q    <= 1'b0;
         busy_q      <= 1'b0;
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
         align_err_q <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         gnt_q       <= gnt_d;
         last_gnt_q  <= last_gnt_d;
         mem_rd_q    <= mem_rd_d;
         mem_wr_q    <= mem_wr_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_ack_q    <= if_ack_d;
         dm_ack_q    <= dm_ack_d;
         busy_q      <= busy_d;
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
         align_err_q <= align_err_d;
`endif
      end
   end

   assign bus.if_ack    = if_ack_q;
   assign bus.if_rdata  = if_rdata_q;
   assign bus.dm_ack    = dm_ack_q;
   assign bus.dm_rdata  = dm_rdata_q;
   assign bus.mem_rd    = mem_rd_q;
   assign bus.mem_wr    = mem_wr_q;
   assign bus.mem_addr  = mem_addr_q;
   assign bus.mem_wdata = mem_wdata_q;
   assign bus.busy      = busy_q;
`ifdef MEM_PORT_ARBITER_ALIGN_CHK_EN
   assign bus.align_err = align_err_q;
`endif

endmodule
